counter_multi_bit: RTL
======================

COUNTER_MULTI_BIT -- requirements
Module: counter_multi_bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter SATURATE, default 0: 0 = wrap mode, 1 = saturate mode.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-low (rst=0 at a rising clk edge resets the block).
REQ-005 Port run, input, 1: count enable, one step per cycle while high.
REQ-006 Port up, input, 1: direction, 1 = increment, 0 = decrement; sampled every cycle.
REQ-007 Port clr, input, 1: synchronous clear of count and status.
REQ-008 Port load, input, 1: synchronous load of load_val.
REQ-009 Port load_val, input, WIDTH: value for load.
REQ-010 Port limit, input, WIDTH: runtime terminal value; count range is 0..limit.
REQ-011 Port count, output, WIDTH: registered counter value.
REQ-012 Port flag, output, 1: combinational terminal indication.
REQ-013 Port wrap, output, 1: registered single-cycle wrap pulse.
REQ-014 Port done, output, 1: registered sticky saturation status.

Function
REQ-015 Per-edge priority SHALL be rst, then clr, then load, then run; the lower-priority actions are ignored in that cycle.
REQ-016 clr SHALL set count=0, wrap=0, done=0, and FSM=IDLE.
REQ-017 load SHALL set count=min(load_val, limit), wrap=0, done=0, and FSM=IDLE.
REQ-018 FSM states SHALL be IDLE, COUNT and DONE.
  - IDLE->COUNT on run.
  - COUNT->IDLE on run=0.
  - COUNT->DONE on a saturation event (SATURATE=1 only).
  - DONE->IDLE only on clr or load.
REQ-019 In IDLE or COUNT with run=1, up=1, count<limit: count SHALL become count+1 at the next edge (latency 1 cycle).
REQ-020 In IDLE or COUNT with run=1, up=0, count>0: count SHALL become count-1 at the next edge.
REQ-021 Up boundary (count>=limit, up=1, run=1), SATURATE=0: count SHALL become 0 and wrap SHALL pulse high for exactly the following cycle.
REQ-022 Down boundary (count==0, up=0, run=1), SATURATE=0: count SHALL become limit and wrap SHALL pulse high for exactly the following cycle.
REQ-023 Either boundary with SATURATE=1: count SHALL hold, done SHALL go 1, and the FSM SHALL enter DONE.
REQ-024 In DONE, run SHALL be ignored, count SHALL hold, and done SHALL stay 1.
REQ-025 wrap SHALL be 0 in every cycle not immediately following a wrap event; back-to-back wraps (e.g. limit=0) SHALL hold wrap high continuously.
REQ-026 flag SHALL be (count==limit) when up=1 and (count==0) when up=0, evaluated combinationally from the current count, limit and up.
REQ-027 With run=0 and no clr or load, count, done and FSM state SHALL hold, and wrap SHALL go 0.
REQ-028 If limit is lowered below the current count:
  - up=1 with run=1 SHALL be treated as the up boundary (REQ-021/023).
  - up=0 SHALL decrement normally.
REQ-029 Arithmetic SHALL be WIDTH bits unsigned; count SHALL never take a value above max(limit, value held before limit changed), and SHALL never wrap through 2^WIDTH.
REQ-030 A direction change mid-count SHALL take effect on the same edge it is sampled, with no extra latency.

Reset
REQ-031 On rst=0 at a rising edge: count=0, wrap=0, done=0, FSM=IDLE, regardless of run, clr or load.
REQ-032 rst asserted mid-count or in DONE SHALL abort the operation; counting SHALL restart from 0 on the first edge with rst=1 and run=1.
REQ-033 rst SHALL have no asynchronous effect; outputs SHALL change only on clk edges (flag follows its inputs combinationally).

Verification
REQ-034 WIDTH=4, SATURATE=0, limit=5, up=1, run=1 for 8 cycles from reset -> count 1,2,3,4,5,0,1,2; flag high while count=5; wrap high only in the cycle count=0.
REQ-035 WIDTH=4, SATURATE=0, limit=9, load with load_val=2, then up=0, run=1 for 4 cycles -> count 1,0,9,8; wrap high only in the cycle count=9.
REQ-036 SATURATE=1, limit=3, up=1, run=1 -> count 1,2,3,3,3; done=1 from the cycle after count first reads 3 at a boundary; clr -> count=0, done=0; load_val=12 with limit=3 -> count=3.
REQ-037 Simultaneous clr=1, load=1, run=1 -> count=0; load=1 with run=1 -> count=load_val, no increment.
REQ-038 rst=0 pulsed while count=7 and run=1 -> count=0, wrap=0, done=0 on that edge; with rst=0 held between edges, no output change until the next edge.

Source files
------------

// File: rtl/counter_multi_bit_if.sv
// Control/status bundle for counter_multi_bit: master drives controls, slave is the counter.
// flag is driven combinationally by the slave; count/wrap/done are registered.
interface counter_multi_bit_if #(
  parameter int WIDTH = 8
);
  logic             run;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             flag;
  logic             wrap;
  logic             done;

  modport master (
    output run, up, clr, load, load_val, limit,
    input  count, flag, wrap, done
  );

  modport slave (
    input  run, up, clr, load, load_val, limit,
    output count, flag, wrap, done
  );
endinterface

// File: rtl/counter_multi_bit.sv
// Up/down counter over 0..limit with wrap or saturate boundary handling; 1-cycle update latency.
// No backpressure: clr > load > run priority is resolved every edge, flag is combinational.
module counter_multi_bit #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  counter_multi_bit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             at_bound;
  logic             active;

  // Up boundary uses >= so a limit lowered under the current count is caught immediately.
  assign at_bound = bus.up ? (count_q >= bus.limit) : (count_q == ZERO);
  assign active   = bus.run && (state_q != ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clr || bus.load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (bus.run) state_d = (SATURATE && at_bound) ? ST_DONE : ST_COUNT;
        ST_COUNT: begin
          if (!bus.run)                 state_d = ST_IDLE;
          else if (SATURATE && at_bound) state_d = ST_DONE;
        end
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    done_d  = done_q;
    if (bus.clr) begin
      count_d = ZERO;
      done_d  = 1'b0;
    end else if (bus.load) begin
      count_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      done_d  = 1'b0;
    end else if (active) begin
      if (!at_bound) begin
        count_d = bus.up ? (count_q + ONE) : (count_q - ONE);
      end else if (SATURATE) begin
        done_d = 1'b1;
      end else begin
        count_d = bus.up ? ZERO : bus.limit;
        wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= ZERO;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.done  = done_q;
  assign bus.flag  = bus.up ? (count_q == bus.limit) : (count_q == ZERO);

endmodule
